// File: rtl/logic_gate_pkg.sv
// logic_gate_pkg: shared FSM encoding, vector count and the expected gate-bank truth table.
package logic_gate_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, DONE = 2'd2} state_t;
  localparam int NUM_VECS = 4;
  localparam int Y_AND = 0;
  localparam int Y_OR = 1;
  localparam int Y_NAND = 2;
  localparam int Y_NOR = 3;
  localparam int Y_XOR = 4;
  function automatic logic [4:0] expected_y(input logic a, input logic b);
    logic [4:0] y;
    y[Y_AND] = a & b;
    y[Y_OR] = a | b;
    y[Y_NAND] = ~(a & b);
    y[Y_NOR] = ~(a | b);
    y[Y_XOR] = a ^ b;
    return y;
  endfunction
endpackage

// File: rtl/logic_gate_expect.sv
// logic_gate_expect: combinational expected outputs of the two-input gate bank.
module logic_gate_expect
  import logic_gate_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output logic [4:0] y
);
  assign y = expected_y(a, b);
endmodule

// File: rtl/logic_gate_checker.sv
// logic_gate_checker: on-board stimulus/response self-test for the mux-built gate bank.
// Define LOGIC_GATE_CHECKER_STOP_ON_FAIL_EN to end a run at its first mismatch.
module logic_gate_checker
  import logic_gate_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int NUM_PASSES = 1,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a_o,
  output logic             b_o,
  input  logic [4:0]       y_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       first_fail_vec,
  output logic [4:0]       first_fail_mask
);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int PW = $clog2(NUM_PASSES + 1);
  state_t state, state_nx;
  logic [1:0] vec, vec_nx, ffv_nx;
  logic [HW-1:0] hold, hold_nx;
  logic [PW-1:0] pcnt, pcnt_nx;
  logic [ERR_W-1:0] err_nx;
  logic [4:0] exp_y, mism, ffm_nx;
  logic pass_nx, sample, bad, last;
  logic_gate_expect u_expect (.a(vec[1]), .b(vec[0]), .y(exp_y));
  assign busy = state == DRIVE;
  assign done = state == DONE;
  assign a_o = busy & vec[1];
  assign b_o = busy & vec[0];
  assign mism = exp_y ^ y_i;
  // only the last hold cycle of a vector is sampled, giving the bank time to settle
  assign sample = busy && hold == HW'(HOLD_CYCLES - 1);
  assign bad = sample && |mism;
`ifdef LOGIC_GATE_CHECKER_STOP_ON_FAIL_EN
  assign last = bad || (sample && vec == 2'(NUM_VECS - 1) && pcnt == PW'(NUM_PASSES - 1));
`else
  assign last = sample && vec == 2'(NUM_VECS - 1) && pcnt == PW'(NUM_PASSES - 1);
`endif
  always_comb begin
    state_nx = state;
    vec_nx = vec;
    hold_nx = hold;
    pcnt_nx = pcnt;
    err_nx = err_count;
    ffv_nx = first_fail_vec;
    ffm_nx = first_fail_mask;
    pass_nx = pass;
    if (busy) begin
      hold_nx = sample ? '0 : hold + HW'(1);
      if (sample) begin
        vec_nx = vec + 2'd1;
        pcnt_nx = vec == 2'(NUM_VECS - 1) ? pcnt + PW'(1) : pcnt;
      end
      if (bad) begin
        err_nx = &err_count ? err_count : err_count + ERR_W'(1);
        ffv_nx = err_count == '0 ? vec : first_fail_vec;
        ffm_nx = err_count == '0 ? mism : first_fail_mask;
      end
      if (last) begin
        state_nx = DONE;
        pass_nx = err_nx == '0;
      end
    end else if (state == IDLE && start) begin
      state_nx = DRIVE;
      vec_nx = '0;
      hold_nx = '0;
      pcnt_nx = '0;
      err_nx = '0;
      ffv_nx = '0;
      ffm_nx = '0;
      pass_nx = 1'b0;
    end else begin
      state_nx = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      vec <= '0;
      hold <= '0;
      pcnt <= '0;
      err_count <= '0;
      first_fail_vec <= '0;
      first_fail_mask <= '0;
      pass <= 1'b0;
    end else begin
      state <= state_nx;
      vec <= vec_nx;
      hold <= hold_nx;
      pcnt <= pcnt_nx;
      err_count <= err_nx;
      first_fail_vec <= ffv_nx;
      first_fail_mask <= ffm_nx;
      pass <= pass_nx;
    end
  end
endmodule

// File: tb/tb_logic_gate_checker.sv
// tb_logic_gate_checker: randomized check of two checker configurations against a cycle-index model.
// Honours LOGIC_GATE_CHECKER_STOP_ON_FAIL_EN the same way the design does.
module tb_logic_gate_checker;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  always #5 clk = ~clk;
`ifdef LOGIC_GATE_CHECKER_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif
  logic [4:0] tt[4], fmask[4];
  logic busy_s[2], done_s[2], a_s[2], b_s[2], pass_s[2];
  logic [1:0] ffv_s[2];
  logic [4:0] ffm_s[2];
  logic [7:0] err_s[2];
  int n_chk = 0, n_fail = 0;
  int bc[2], dc[2];
  logic ea, eb;
  logic [4:0] ey;
  logic_gate_expect u_exp (.a(ea), .b(eb), .y(ey));
  // cfg[0]: defaults; cfg[1]: HOLD 3, 3 passes, 3-bit saturating error counter
  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int E = g == 0 ? 8 : 3;
    logic [4:0] y;
    logic [E-1:0] err;
    assign y = tt[{a_s[g], b_s[g]}] ^ fmask[{a_s[g], b_s[g]}];
    assign err_s[g] = 8'(err);
    logic_gate_checker #(.HOLD_CYCLES(g == 0 ? 4 : 3), .NUM_PASSES(g == 0 ? 1 : 3), .ERR_W(E)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a_o(a_s[g]), .b_o(b_s[g]), .y_i(y),
      .busy(busy_s[g]), .done(done_s[g]), .pass(pass_s[g]), .err_count(err),
      .first_fail_vec(ffv_s[g]), .first_fail_mask(ffm_s[g]));
  end
  // model: mk = 1-based cycle index inside a run (0 when not running)
  int mk[2], errs[2];
  bit mdone[2], mpass[2];
  logic [1:0] mffv[2];
  logic [4:0] mffm[2];
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      int h, n;
      logic [1:0] v;
      logic [4:0] mm;
      h = g == 0 ? 4 : 3;
      n = g == 0 ? 16 : 36;
      if (!rst_n) begin
        mk[g] = 0; mdone[g] = 0; mpass[g] = 0; errs[g] = 0; mffv[g] = 0; mffm[g] = 0;
      end else if (mdone[g]) begin
        mdone[g] = 0;
      end else if (mk[g] == 0) begin
        if (start) begin
          mk[g] = 1; errs[g] = 0; mpass[g] = 0; mffv[g] = 0; mffm[g] = 0;
        end
      end else begin
        v = 2'(((mk[g] - 1) / h) % 4);
        mm = (mk[g] % h == 0) ? fmask[v] : 5'd0;
        if (mm != 5'd0) begin
          if (errs[g] == 0) begin
            mffv[g] = v;
            mffm[g] = mm;
          end
          errs[g]++;
        end
        if (mk[g] == n || (STOP && mm != 5'd0)) begin
          mk[g] = 0; mdone[g] = 1; mpass[g] = errs[g] == 0;
        end else begin
          mk[g]++;
        end
      end
    end
    #1;
    for (int g = 0; g < 2; g++) begin
      int h, mx, ev;
      logic [1:0] v;
      logic on;
      logic [11:0] got, want;
      h = g == 0 ? 4 : 3;
      mx = g == 0 ? 255 : 7;
      on = mk[g] != 0;
      v = on ? 2'(((mk[g] - 1) / h) % 4) : 2'd0;
      ev = errs[g] > mx ? mx : errs[g];
      want = {on, mdone[g], on & v[1], on & v[0], mpass[g], mffv[g], mffm[g]};
      got = {busy_s[g], done_s[g], a_s[g], b_s[g], pass_s[g], ffv_s[g], ffm_s[g]};
      n_chk++;
      if (got !== want || int'(err_s[g]) != ev) begin
        n_fail++;
        $display("FAIL cfg%0d outputs at %0t: got busy/done/a/b/pass/ffv/ffm %b err %0d, want %b err %0d",
                 g, $time, got, err_s[g], want, ev);
      end
    end
  end
  task automatic chk(input string nm, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask
  task automatic run(input logic [4:0] m0, m1, m2, m3, input bit repulse);
    @(negedge clk);
    fmask[0] = m0; fmask[1] = m1; fmask[2] = m2; fmask[3] = m3;
    start = 1'b1;
    bc = '{0, 0};
    dc = '{0, 0};
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      start = repulse && (i == 2 || i == 3);
      for (int g = 0; g < 2; g++) begin
        bc[g] += int'(busy_s[g]);
        dc[g] += int'(done_s[g]);
      end
    end
  endtask
  initial begin
    int found;
    tt[0] = 5'b01100; tt[1] = 5'b10110; tt[2] = 5'b10110; tt[3] = 5'b00011;
    for (int i = 0; i < 4; i++) fmask[i] = 5'd0;
    ea = 1'b0; eb = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", int'(busy_s[0]), 0);
    chk("reset a_o", int'(a_s[0]), 0);
    chk("reset err", int'(err_s[0]), 0);
    for (int v = 0; v < 4; v++) begin
      {ea, eb} = 2'(v);
      #1 chk("expect table", int'(ey), int'(tt[v]));
    end
    rst_n = 1'b1;
    run(5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("clean busy cycles", bc[0], 16);
    chk("clean done pulses", dc[0], 1);
    chk("clean pass", int'(pass_s[0]), 1);
    chk("clean err", int'(err_s[0]), 0);
    chk("clean cfg1 busy cycles", bc[1], 36);
    run(5'd0, 5'b10000, 5'b10000, 5'd0, 1'b1);
    chk("y5 stuck err", int'(err_s[0]), STOP ? 1 : 2);
    chk("y5 stuck first vec", int'(ffv_s[0]), 1);
    chk("y5 stuck first mask", int'(ffm_s[0]), 16);
    chk("y5 stuck pass", int'(pass_s[0]), 0);
    chk("y5 stuck busy cycles", bc[0], STOP ? 8 : 16);
    chk("y5 stuck cfg1 err", int'(err_s[1]), STOP ? 1 : 6);
    chk("y5 stuck cfg1 busy cycles", bc[1], STOP ? 6 : 36);
    chk("y5 stuck cfg1 done pulses", dc[1], 1);
    run(5'h1f, 5'h1f, 5'h1f, 5'h1f, 1'b0);
    chk("inverted err", int'(err_s[0]), STOP ? 1 : 4);
    chk("inverted first vec", int'(ffv_s[0]), 0);
    chk("inverted first mask", int'(ffm_s[0]), 31);
    chk("inverted cfg1 saturated err", int'(err_s[1]), STOP ? 1 : 7);
    @(negedge clk);
    for (int i = 0; i < 4; i++) fmask[i] = STOP ? 5'd0 : 5'h1f;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (a_s[0] && !b_s[0]) found = 1;
      else @(negedge clk);
    end
    chk("midrun reached vec 2", found, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrun reset busy", int'(busy_s[0]), 0);
    chk("midrun reset a_o/b_o", int'({a_s[0], b_s[0]}), 0);
    chk("midrun reset err", int'(err_s[0]), 0);
    found = 0;
    repeat (40) begin
      @(negedge clk);
      found += int'(done_s[0]) + int'(done_s[1]);
    end
    chk("midrun reset no done", found, 0);
    run(5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("after reset busy cycles", bc[0], 16);
    chk("after reset pass", int'(pass_s[0]), 1);
    for (int r = 0; r < 8; r++)
      run($urandom_range(0, 1) ? 5'($urandom_range(0, 31)) : 5'd0,
          $urandom_range(0, 1) ? 5'($urandom_range(0, 31)) : 5'd0,
          $urandom_range(0, 1) ? 5'($urandom_range(0, 31)) : 5'd0,
          $urandom_range(0, 1) ? 5'($urandom_range(0, 31)) : 5'd0,
          1'($urandom_range(0, 1)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/logic_gate_checker.md
Name: logic_gate_checker

Overview:
- Synthesizable stimulus-and-response checker for the two-input gate bank built from 2x1 muxes.
- Drives the bank's a/b inputs through all four input combinations and samples its five gate outputs.
- Compares each sample against the expected truth table and reports pass/fail, error count and first failure.
- Sits opposite the gate bank on its a/b -> y1..y5 interface; used for on-board self-test in place of a simulation-only bench.

Parameters:
- HOLD_CYCLES, 4: cycles each input vector is held; legal range >= 2.
- NUM_PASSES, 1: number of full 4-vector sweeps per run; legal range >= 1.
- ERR_W, 8: width of err_count; the counter saturates.

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  single-cycle run request; honoured only in IDLE
- a_o  output  1  stimulus to gate-bank input a (registered)
- b_o  output  1  stimulus to gate-bank input b (registered)
- y_i  input  5  gate-bank outputs; y_i[0]=y1 ... y_i[4]=y5
- busy  output  1  high while a run is in progress
- done  output  1  one-cycle pulse at end of run
- pass  output  1  result of the last run, held until next start
- err_count  output  ERR_W  mismatching samples in the current/last run
- first_fail_vec  output  2  {a,b} of the first mismatching vector
- first_fail_mask  output  5  per-bit mismatch mask of the first failure

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at an edge) takes effect on that edge, including mid-run. All outputs become 0: a_o, b_o, busy, done, pass, err_count, first_fail_vec, first_fail_mask. State goes to IDLE.
- Expected function:
  - y1 = a AND b
  - y2 = a OR b
  - y3 = a NAND b
  - y4 = a NOR b
  - y5 = a XOR b
- Vector order: vec 0..3, with a_o = vec[1] and b_o = vec[0]; i.e. 00, 01, 10, 11. After vec 3 the sequence wraps to 00 if passes remain.
- States: IDLE, DRIVE, DONE.
- IDLE:
  - a_o = b_o = 0; busy = 0.
  - start=1 at an edge leads to DRIVE on that edge: vec=0, hold_cnt=0, pass_cnt=0, busy=1.
  - On the same edge err_count, first_fail_* and pass are cleared.
- DRIVE:
  - a_o/b_o reflect vec; hold_cnt increments each cycle.
  - At the edge where hold_cnt == HOLD_CYCLES-1, y_i is sampled and compared.
  - On mismatch:
    - err_count increments, saturating at 2^ERR_W-1.
    - On the first mismatch of the run, first_fail_vec and first_fail_mask (expected XOR y_i) are latched.
  - Then hold_cnt resets to 0 and vec advances.
  - After the last vector of pass NUM_PASSES-1, go to DONE.
- DONE: lasts one cycle. done=1, busy=0, a_o=b_o=0, pass=(err_count==0). Then IDLE.
- Run length: busy is high for exactly 4*HOLD_CYCLES*NUM_PASSES cycles. done follows on the next cycle.
- start while busy or in DONE is ignored; start held high does not cause a double run inside the run. It is re-sampled only in IDLE.
- The sample on the final hold cycle is counted before the DONE transition; it is never dropped.
- The first hold cycle after a vector change is never sampled; this gives the gate bank settling time.

Optional Feature:
- Macro: LOGIC_GATE_CHECKER_STOP_ON_FAIL_EN.
- Defined: the first mismatch ends the run. The state goes to DONE on the next edge, with err_count=1 and pass=0; the remaining vectors are skipped.
- Undefined: the run always completes all vectors and passes, and err_count totals every mismatch.

Decomposition:
- Shared package/include logic_gate_pkg holds:
  - state encodings (IDLE=2'd0, DRIVE=2'd1, DONE=2'd2)
  - NUM_VECS=4
  - gate-output index constants Y_AND..Y_XOR
  - function expected_y(a,b) returning 5 bits
- One natural sub-module: logic_gate_expect, a combinational 2-in/5-out expected-value generator. It is reused by the checker and by the bench scoreboard.

Test Plan:
- Correct gate bank connected, defaults, one start pulse -> busy high 16 cycles, done pulse on cycle 17, pass=1, err_count=0.
- y5 tied 0 -> mismatches at vec 01 and 10; err_count=2, first_fail_vec=2'b01, first_fail_mask=5'b10000, pass=0.
- All y_i inverted -> err_count=4, first_fail_vec=2'b00, first_fail_mask=5'b11111.
- rst_n low during vec 2 -> next edge busy=0, a_o=b_o=0, err_count=0, no done. A new start then runs the full 16 cycles.
- NUM_PASSES=3, y5 tied 0, start re-pulsed mid-run -> busy 48 cycles, a single done, err_count=6.
- STOP_ON_FAIL_EN defined, y5 tied 0 -> done after the vec 01 sample (cycle 8), err_count=1, first_fail_vec=2'b01, pass=0.
